matrix_hex_writer: RTL and testbench
====================================

# matrix_hex_writer

Serializes an 8-bit row×column matrix into the team's test-vector text format, one ASCII character per transfer: each row is `hh_hh_..._hh` followed by a line feed, with lowercase hex digits. It is the producing end of the test-vector file format: it sits between a matrix source (DUT output or golden model) and a character sink such as a UART transmitter or file-dump shim. Its output can be read back by the existing vector-file parsers without modification.

## Interface
- `row`, 4, number of matrix rows (≥1)
- `column`, 4, number of elements per row (≥1)

- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  begin a dump; sampled only in IDLE
- `in_mat`  input  [7:0] unpacked [0:row-1][0:column-1]  matrix to dump; captured on accepted `start`
- `busy`  output  1  high from the cycle after `start` is accepted until the `done` cycle, inclusive
- `done`  output  1  one-cycle pulse after the final line feed is accepted
- `char_data`  output  8  ASCII character
- `char_valid`  output  1  `char_data` is valid
- `char_ready`  input  1  sink accepts the character; transfer occurs when `char_valid && char_ready`

## Operation
- States:
  - IDLE: waits for `start`.
  - HI: high nibble of the current element.
  - LO: low nibble of the current element.
  - SEP: `_` (0x5F).
  - EOL: line feed (0x0A).
  - DONE: one cycle.
- Transitions, each taken on an accepted transfer:
  - IDLE→HI when `start` is high; `in_mat` is snapshotted into an internal buffer and the row and column counters are cleared.
  - HI→LO.
  - LO→SEP if `col < column-1`, else LO→EOL.
  - SEP→HI with `col` incremented.
  - EOL→HI with `row` incremented and `col` cleared, if `row < row-1`; else EOL→DONE.
  - DONE→IDLE unconditionally.
- Nibble encoding: 0–9 map to 0x30–0x39; a–f map to 0x61–0x66 (lowercase, no uppercase option).
- Characters per dump: `row*3*column`. Example: 4×4 gives 48.
- The snapshot makes later changes to `in_mat` during a dump invisible to the output.
- `start` asserted while not in IDLE (including the DONE cycle) is ignored; it is not queued.
- Counter widths are `$clog2(row)` and `$clog2(column)`, each with a minimum of 1 bit.
- `column=1` gives no SEP state in a row. `row=1` goes from EOL straight to DONE.

## Timing
- Reset values: `char_valid=0`, `char_data=0x00`, `busy=0`, `done=0`, state IDLE, counters 0.
- Reset asserted mid-dump aborts immediately. No `done` is produced. After reset deasserts, the block idles until a fresh `start`.
- Latency: with `start` high in cycle 0, cycle 1 has `char_valid=1`, `busy=1`, and the first HI digit on `char_data`.
- With `char_ready` held high, one character is transferred per cycle. For the 4×4 case, the last line feed transfers in cycle 48, `done=1` in cycle 49, and `busy=0` from cycle 50.
- Handshake rule: while `char_valid && !char_ready`, `char_data` and `char_valid` hold stable. `char_valid` never drops without a transfer.
- Outputs are registered; there is no combinational path from `char_ready` to `char_data`.
- `char_valid` is 0 in IDLE and DONE.

## Structure
- Package `matrix_pkg` holds:
  - state enum `writer_state_t`;
  - ASCII constants `ASCII_SEP` (0x5F) and `ASCII_EOL` (0x0A);
  - function `nibble_to_ascii(logic [3:0]) -> logic [7:0]`.
- The block is a single module with no sub-module; the nibble conversion is the package function.

## Test plan
- 4×4 matrix with elements `i*4+j`, `char_ready=1` → stream is exactly `00_01_02_03\n04_05_06_07\n08_09_0a_0b\n0c_0d_0e_0f\n`; `done` pulses in cycle 49.
- Element 0xAB with elements 0xFF elsewhere → the chars for 0xAB are 0x61, 0x62 (lowercase); the chars for 0xFF are `ff`.
- Random `char_ready` (50% duty) → same 48-char stream; `char_data` is stable on every stalled cycle; the checker parses the output back to the input matrix.
- `in_mat` changed and `start` re-pulsed in cycle 10 of a dump → output still matches the original snapshot; no second dump starts.
- `rst` asserted in cycle 20 → all outputs 0 on the same edge and no `done`; a new `start` after release produces the full 48-char stream.
- Parameters row=2, column=6 → 36 characters, each line has 5 separators, `done` after the second line feed.

Source files
------------

// File: rtl/matrix_hex_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_pkg
//  Brief    : Shared types, ASCII constants and nibble encoder for the
//             matrix hex writer.
//  Revision : 1.0
// ============================================================================
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_SEP  = 3'd3,
        ST_EOL  = 3'd4,
        ST_DONE = 3'd5
    } writer_state_t;

    localparam logic [7:0] ASCII_SEP = 8'h5F;
    localparam logic [7:0] ASCII_EOL = 8'h0A;

    // Lowercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'a'..'f'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_hex_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_hex_writer_if
//  Brief    : Control and character-stream handshake of the matrix hex writer.
//  Revision : 1.0
// ============================================================================
interface matrix_hex_writer_if;

    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;

    modport master (
        input  start,
        input  char_ready,
        output busy,
        output done,
        output char_data,
        output char_valid
    );

    modport slave (
        output start,
        output char_ready,
        input  busy,
        input  done,
        input  char_data,
        input  char_valid
    );

endinterface
`default_nettype wire

// File: rtl/matrix_hex_writer.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_hex_writer
//  Brief    : Serializes a ROW x COLUMN byte matrix as "hh_hh_..._hh\n" lines,
//             one ASCII character per valid/ready transfer.
//  Revision : 1.0
// ============================================================================
module matrix_hex_writer
    import matrix_pkg::*;
#(
    parameter int ROW    = 4,
    parameter int COLUMN = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [7:0]       in_mat [0:ROW-1][0:COLUMN-1],
    matrix_hex_writer_if.master   bus
);

    localparam int c_row_w = (ROW    > 1) ? $clog2(ROW)    : 1;
    localparam int c_col_w = (COLUMN > 1) ? $clog2(COLUMN) : 1;
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ROW - 1);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(COLUMN - 1);

    writer_state_t        r_state;
    writer_state_t        w_state_nxt;
    logic [c_row_w-1:0]   r_row;
    logic [c_row_w-1:0]   w_row_nxt;
    logic [c_col_w-1:0]   r_col;
    logic [c_col_w-1:0]   w_col_nxt;
    logic                 w_load;
    logic                 w_fire;
    logic [7:0]           w_elem;
    logic [7:0]           w_char_nxt;
    logic [7:0]           r_buf [0:ROW-1][0:COLUMN-1];
    logic [7:0]           r_char_data;
    logic                 r_char_valid;
    logic                 r_busy;
    logic                 r_done;

    assign w_fire = r_char_valid & bus.char_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_HI;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_HI: begin
                if (w_fire) w_state_nxt = ST_LO;
            end
            ST_LO: begin
                if (w_fire) w_state_nxt = (r_col == c_col_last) ? ST_EOL : ST_SEP;
            end
            ST_SEP: begin
                if (w_fire) begin
                    w_state_nxt = ST_HI;
                    w_col_nxt   = r_col + c_col_w'(1);
                end
            end
            ST_EOL: begin
                if (w_fire) begin
                    if (r_row == c_row_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_HI;
                        w_row_nxt   = r_row + c_row_w'(1);
                        w_col_nxt   = '0;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The snapshot is written on the same edge, so the first digit comes from in_mat
    always_comb begin
        w_elem     = w_load ? in_mat[0][0] : r_buf[w_row_nxt][w_col_nxt];
        w_char_nxt = 8'h00;
        case (w_state_nxt)
            ST_HI:   w_char_nxt = nibble_to_ascii(w_elem[7:4]);
            ST_LO:   w_char_nxt = nibble_to_ascii(w_elem[3:0]);
            ST_SEP:  w_char_nxt = ASCII_SEP;
            ST_EOL:  w_char_nxt = ASCII_EOL;
            default: w_char_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_load) r_buf <= in_mat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_char_data  <= 8'h00;
            r_char_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_char_data  <= w_char_nxt;
            r_char_valid <= (w_state_nxt == ST_HI)  || (w_state_nxt == ST_LO) ||
                            (w_state_nxt == ST_SEP) || (w_state_nxt == ST_EOL);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.char_data  = r_char_data;
    assign bus.char_valid = r_char_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_hex_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_hex_writer
//  Brief    : Self-checking bench for matrix_hex_writer (4x4 and 2x6 builds).
//  Revision : 1.0
// ============================================================================
module tb_matrix_hex_writer;

    typedef struct {
        int pat;            // 0: i*4+j, 1: 0xAB then 0xFF, 2: random
        int duty;           // char_ready duty in percent
        int disturb;        // cycle to change in_mat and re-pulse start (-1: none)
        int rst_at;         // cycle to assert reset (-1: none)
        int exp_chars;      // characters expected before done
        int exp_done_cyc;   // expected done cycle (-1: don't care / none)
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_hex_writer_if bus_a ();
    matrix_hex_writer_if bus_b ();
    logic [7:0] mat_a   [0:3][0:3];
    logic [7:0] mat_ref [0:3][0:3];
    logic [7:0] mat_b   [0:1][0:5];

    matrix_hex_writer #(.ROW(4), .COLUMN(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_mat(mat_a), .bus(bus_a)
    );
    matrix_hex_writer #(.ROW(2), .COLUMN(6)) u_dut_b (
        .clk(clk), .rst(rst), .in_mat(mat_b), .bus(bus_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got [0:63];
    int         n_got;
    vec_t       vecs [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h61 + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [3:0] unhex(input logic [7:0] ch);
        if (ch >= 8'h61) return 4'(ch - 8'h57);
        return 4'(ch - 8'h30);
    endfunction

    task automatic fill_a(input int pat);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                case (pat)
                    0:       mat_a[r][c] = 8'(r * 4 + c);
                    1:       mat_a[r][c] = (r == 0 && c == 0) ? 8'hAB : 8'hFF;
                    default: mat_a[r][c] = 8'($urandom_range(255));
                endcase
                mat_ref[r][c] = mat_a[r][c];
            end
    endtask

    task automatic push_expected_a();
        exp_q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back(hexc(mat_ref[r][c][7:4]));
                exp_q.push_back(hexc(mat_ref[r][c][3:0]));
                exp_q.push_back((c < 3) ? 8'h5F : 8'h0A);
            end
    endtask

    task automatic run_a(input vec_t v);
        int         done_cyc;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        fill_a(v.pat);
        push_expected_a();
        n_got      = 0;
        done_cyc   = -1;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        @(negedge clk);
        bus_a.start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus_a.start = 1'b0;
                check("first_valid", 32'(bus_a.char_valid), 32'd1);
                check("first_busy",  32'(bus_a.busy),       32'd1);
            end
            if (cyc == v.disturb) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) mat_a[r][c] = 8'h5A;
                bus_a.start = 1'b1;
            end
            if (cyc == v.disturb + 1) bus_a.start = 1'b0;
            if (cyc == v.rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_valid", 32'(bus_a.char_valid), 32'd0);
                check("rst_data",  32'(bus_a.char_data),  32'd0);
                check("rst_busy",  32'(bus_a.busy),       32'd0);
                check("rst_done",  32'(bus_a.done),       32'd0);
                exp_q.delete();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("rst_hold_done", 32'(bus_a.done), 32'd0);
                end
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("post_rst_idle", 32'({bus_a.busy, bus_a.char_valid, bus_a.done}), 32'd0);
                end
                return;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(bus_a.char_valid), 32'd1);
                check("stall_data",  32'(bus_a.char_data),  32'(prev_data));
            end
            bus_a.char_ready = ($urandom_range(99) < v.duty);
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("done_pulse", 32'(bus_a.done), 32'd0);
                check("busy_after", 32'(bus_a.busy), 32'd0);
                break;
            end
            if (bus_a.done) begin
                done_cyc = cyc;
                check("done_valid", 32'(bus_a.char_valid), 32'd0);
                check("done_busy",  32'(bus_a.busy),       32'd1);
            end
            if (bus_a.char_valid && bus_a.char_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_char", 32'(bus_a.char_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("char", 32'(bus_a.char_data), 32'(e));
                end
                if (n_got < 64) got[n_got] = bus_a.char_data;
                n_got++;
            end
            prev_stall = bus_a.char_valid && !bus_a.char_ready;
            prev_data  = bus_a.char_data;
        end
        check("done_seen",  32'(done_cyc >= 0), 32'd1);
        check("char_count", 32'(n_got), 32'(v.exp_chars));
        check("queue_left", 32'(exp_q.size()), 32'd0);
        if (v.exp_done_cyc >= 0) check("done_cycle", 32'(done_cyc), 32'(v.exp_done_cyc));
        if (v.disturb >= 0) begin
            repeat (5) @(negedge clk);
            check("no_second_dump", 32'({bus_a.busy, bus_a.char_valid}), 32'd0);
        end
    endtask

    initial begin
        string      lit;
        logic [7:0] lc;
        logic [7:0] pv;
        int         seps;
        int         lfs;
        int         done_cyc;
        logic [7:0] e;

        vecs[0] = '{pat: 0, duty: 100, disturb: -1, rst_at: -1, exp_chars: 48, exp_done_cyc: 49};
        vecs[1] = '{pat: 1, duty: 100, disturb: -1, rst_at: -1, exp_chars: 48, exp_done_cyc: 49};
        vecs[2] = '{pat: 2, duty: 50,  disturb: -1, rst_at: -1, exp_chars: 48, exp_done_cyc: -1};
        vecs[3] = '{pat: 0, duty: 100, disturb: 10, rst_at: -1, exp_chars: 48, exp_done_cyc: 49};
        vecs[4] = '{pat: 2, duty: 100, disturb: -1, rst_at: 20, exp_chars: 0,  exp_done_cyc: -1};
        vecs[5] = '{pat: 0, duty: 100, disturb: -1, rst_at: -1, exp_chars: 48, exp_done_cyc: 49};

        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.char_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.char_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 6; c++) mat_b[r][c] = 8'(r * 16 + c);
        fill_a(0);
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(bus_a.char_valid), 32'd0);
        check("reset_data",  32'(bus_a.char_data),  32'd0);
        check("reset_busy",  32'(bus_a.busy),       32'd0);
        check("reset_done",  32'(bus_a.done),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        lit = "00_01_02_03\n04_05_06_07\n08_09_0a_0b\n0c_0d_0e_0f\n";
        for (int i = 0; i < 6; i++) begin
            run_a(vecs[i]);
            if (vecs[i].pat == 0 && vecs[i].rst_at < 0) begin
                for (int k = 0; k < 48; k++) begin
                    lc = lit[k];
                    check("literal_stream", 32'(got[k]), 32'(lc));
                end
            end
            if (vecs[i].pat == 1) begin
                check("ab_hi", 32'(got[0]), 32'h61);
                check("ab_lo", 32'(got[1]), 32'h62);
                check("ff_hi", 32'(got[3]), 32'h66);
                check("ff_lo", 32'(got[4]), 32'h66);
            end
            if (vecs[i].duty < 100) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        pv = {unhex(got[r*12 + c*3]), unhex(got[r*12 + c*3 + 1])};
                        check("parse_back", 32'(pv), 32'(mat_ref[r][c]));
                    end
            end
            repeat (2) @(negedge clk);
        end

        // 2x6 build: 36 characters, five separators per line
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 6; c++) begin
                exp_q.push_back(hexc(mat_b[r][c][7:4]));
                exp_q.push_back(hexc(mat_b[r][c][3:0]));
                exp_q.push_back((c < 5) ? 8'h5F : 8'h0A);
            end
        n_got = 0; seps = 0; lfs = 0; done_cyc = -1;
        @(negedge clk);
        bus_b.start = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.done) begin
                done_cyc = cyc;
                check("b_done_after_lf2", 32'(lfs), 32'd2);
                break;
            end
            if (bus_b.char_valid && bus_b.char_ready) begin
                if (exp_q.size() == 0) begin
                    check("b_extra_char", 32'(bus_b.char_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("b_char", 32'(bus_b.char_data), 32'(e));
                end
                n_got++;
                if (bus_b.char_data == 8'h5F) seps++;
                if (bus_b.char_data == 8'h0A) begin
                    lfs++;
                    check("b_line_seps", 32'(seps), 32'd5);
                    seps = 0;
                end
            end
        end
        check("b_char_count", 32'(n_got), 32'd36);
        check("b_done_cycle", 32'(done_cyc), 32'd37);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
